aes128_encrypt: RTL and testbench

// - Iterative AES-128 encryption core (FIPS-197): one round per clock, full 128-bit datapath.
// - Expands the cipher key combinationally into an internal 11x128-bit round-key schedule.
// - Applies initial AddRoundKey, 9 full rounds, then the final round (no MixColumns).
// - Standalone leaf of the crypto subsystem; the result holds on cipher until the next reset.

---
 rtl/aes_pkg.sv | 66 ++++++
 rtl/add_round_key.sv | 12 +
 rtl/encrypt_last_round.sv | 12 +
 rtl/encrypt_round.sv | 12 +
 rtl/key_expansion.sv | 29 ++
 rtl/aes128_encrypt.sv | 64 ++++++
 tb/tb_aes128_encrypt.sv | 124 ++++++++++++
 7 files changed

// File: rtl/aes_pkg.sv
// AES-128 shared definitions: S-box ROM, GF(2^8) helpers, round constants
// and the byte-level round transforms used by the round sub-modules.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_NR      = 10;

  // Round constants for key-schedule words 4, 8, ..., 40.
  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // S-box ROM, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes followed by ShiftRows; byte 4*c+r of the block is s[r][c].
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127 - 8 * (4 * c + r) -: 8] = sbox(s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8]);
      end
    end
    return res;
  endfunction

  // MixColumns with matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2].
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] res;
    logic [7:0]   a0, a1, a2, a3;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      res[127 - 32 * c -: 32] = {
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
      };
    end
    return res;
  endfunction

endpackage

// File: rtl/add_round_key.sv
// Initial whitening step: XOR the block with a round key.
module add_round_key
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] data,
  input  logic [AES_BLOCK_W-1:0] rk,
  output logic [AES_BLOCK_W-1:0] result
);

  assign result = data ^ rk;

endmodule

// File: rtl/encrypt_last_round.sv
// Final AES round: SubBytes, ShiftRows, AddRoundKey (no MixColumns).
module encrypt_last_round
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] data,
  input  logic [AES_BLOCK_W-1:0] rk,
  output logic [AES_BLOCK_W-1:0] result
);

  assign result = sub_shift(data) ^ rk;

endmodule

// File: rtl/encrypt_round.sv
// One full AES round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
module encrypt_round
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] data,
  input  logic [AES_BLOCK_W-1:0] rk,
  output logic [AES_BLOCK_W-1:0] result
);

  assign result = mix_columns(sub_shift(data)) ^ rk;

endmodule

// File: rtl/key_expansion.sv
// Combinational AES-128 key schedule; round key r sits at key_schedule[128*r +: 128].
module key_expansion
  import aes_pkg::*;
(
  input  logic [127:0]  key,
  output logic [1407:0] key_schedule
);

  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [1407:0] ks;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t[31:24] = t[31:24] ^ RCON[i / 4 - 1];
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++) ks[128 * r +: 128] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    return ks;
  endfunction

  assign key_schedule = expand(key);

endmodule

// File: rtl/aes128_encrypt.sv
// Iterative AES-128 encryption core: one round per clock after reset release,
// ciphertext held on cipher with done=1 until the next reset.
module aes128_encrypt
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = AES_NR
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [AES_BLOCK_W-1:0] message,
  input  logic [32*NK-1:0]       key,
  output logic [AES_BLOCK_W-1:0] cipher,
  output logic                   done
);

  localparam logic [3:0] RND_LAST = 4'(NR);
  localparam logic [3:0] RND_DONE = 4'(NR + 1);

  logic [3:0]             rnd;
  logic [3:0]             rk_sel;
  logic [1407:0]          key_schedule;
  logic [AES_BLOCK_W-1:0] state;
  logic [AES_BLOCK_W-1:0] state_next;
  logic [AES_BLOCK_W-1:0] rk;
  logic [AES_BLOCK_W-1:0] ark_out;
  logic [AES_BLOCK_W-1:0] round_out;
  logic [AES_BLOCK_W-1:0] last_out;

  key_expansion u_key_expansion (.key(key), .key_schedule(key_schedule));

  // Once the counter saturates the key select stays on the last round key.
  assign rk_sel = (rnd > RND_LAST) ? RND_LAST : rnd;
  assign rk     = key_schedule[128 * int'(rk_sel) +: 128];

  add_round_key      u_ark   (.data(message), .rk(rk), .result(ark_out));
  encrypt_round      u_round (.data(state),   .rk(rk), .result(round_out));
  encrypt_last_round u_last  (.data(state),   .rk(rk), .result(last_out));

  // Pick the transform for the current round; hold the state once finished.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    if (rnd == 4'd0)          state_next = ark_out;
    else if (rnd < RND_LAST)  state_next = round_out;
    else if (rnd == RND_LAST) state_next = last_out;
  end

  // Round counter and state register; reset aborts and restarts the encryption.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rnd   <= 4'd0;
      state <= '0;
    end else if (rnd <= RND_LAST) begin
      // NOTE: non-blocking so rnd and state update together from pre-edge values.
      rnd   <= rnd + 4'd1;
      state <= state_next;
    end
  end

  assign cipher = state;
  assign done   = (rnd == RND_DONE);

endmodule

// File: tb/tb_aes128_encrypt.sv
// Directed bench for aes128_encrypt: known-answer vectors plus reset and hold sequences.
module tb_aes128_encrypt;

  typedef struct {
    string        name;
    logic [127:0] message;
    logic [127:0] key;
    logic [127:0] cipher;
  } vector_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] message = '0;
  logic [127:0] key = '0;
  logic [127:0] cipher;
  logic         done;

  int checks = 0;
  int errors = 0;

  aes128_encrypt dut (
    .clk(clk), .reset(reset), .message(message), .key(key), .cipher(cipher), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Load inputs and pulse reset, releasing on a falling edge.
  task automatic start(input logic [127:0] m, input logic [127:0] k);
    @(negedge clk);
    message = m;
    key     = k;
    reset   = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
  endtask

  // Advance n rising edges, then sample just after the last one.
  task automatic run_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vector_t vecs [3];
  logic [127:0] held;

  initial begin
    vecs[0] = '{"two_one_nine_two", 128'h54776F204F6E65204E696E652054776F,
                128'h5468617473206D79204B756E67204675, 128'h29C3505F571420F6402299B31A02D73A};
    vecs[1] = '{"fips_c1", 128'h00112233445566778899AABBCCDDEEFF,
                128'h000102030405060708090A0B0C0D0E0F, 128'h69C4E0D86A7B0430D8CDB78070B4C55A};
    vecs[2] = '{"fips_b", 128'h3243F6A8885A308D313198A2E0370734,
                128'h2B7E151628AED2A6ABF7158809CF4F3C, 128'h3925841D02DC09FBDC118597196A0B32};

    // Reset held across several clock edges keeps everything cleared.
    message = vecs[0].message;
    key     = vecs[0].key;
    run_edges(3);
    check("held_reset_cipher", cipher, 128'h0);
    check("held_reset_done", 128'(done), 128'h0);
    check("held_reset_rnd", 128'(dut.rnd), 128'h0);

    // Known-answer vectors: first-round whitening, done low before the end, final result.
    for (int i = 0; i < 3; i++) begin
      start(vecs[i].message, vecs[i].key);
      #1;
      check({vecs[i].name, "_after_release"}, {cipher[127:1], done}, 128'h0);
      run_edges(1);
      check({vecs[i].name, "_whitened"}, cipher, vecs[i].message ^ vecs[i].key);
      run_edges(9);
      check({vecs[i].name, "_done_early"}, 128'(done), 128'h0);
      run_edges(1);
      check({vecs[i].name, "_cipher"}, cipher, vecs[i].cipher);
      check({vecs[i].name, "_done"}, 128'(done), 128'h1);
    end

    // Last round key of the FIPS-197 appendix key.
    check("rk10_fips_key", dut.key_schedule[1280 +: 128], 128'hD014F9A8C9EE2589E13F0CC8B6630CA6);

    // Asynchronous reset in the middle of an encryption, held over edges, then restart.
    start(vecs[0].message, vecs[0].key);
    run_edges(5);
    #2;
    reset = 1'b1;
    #1;
    check("abort_cipher", cipher, 128'h0);
    check("abort_done", 128'(done), 128'h0);
    run_edges(2);
    check("abort_held_rnd", 128'(dut.rnd), 128'h0);
    @(negedge clk);
    reset = 1'b0;
    run_edges(10);
    check("restart_done_early", 128'(done), 128'h0);
    run_edges(1);
    check("restart_cipher", cipher, vecs[0].cipher);
    check("restart_done", 128'(done), 128'h1);

    // Result holds for 20 further cycles.
    held = cipher;
    for (int c = 0; c < 20; c++) begin
      run_edges(1);
      check("hold_cipher", cipher, held);
      check("hold_done", 128'(done), 128'h1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected finish before 200000");
    $fatal(1);
  end

endmodule
